// File: rtl/requant_pkg.sv
// rtl/requant_pkg.sv - shared widths, types and helpers for the int8 requantizer
package requant_pkg;

  localparam int LANES   = 4;
  localparam int ACC_W   = 32;
  localparam int OUT_W   = 8;
  localparam int SCALE_W = 16;
  localparam int SHIFT_W = 5;
  localparam int PROD_W  = 49;
  localparam int CNT_W   = 16;
  localparam int POP_W   = $clog2(LANES + 1);

  typedef logic signed [ACC_W-1:0]  acc_t;
  typedef logic signed [OUT_W-1:0]  q8_t;
  typedef logic signed [PROD_W-1:0] prod_t;

  typedef struct packed {
    logic [SCALE_W-1:0] scale;
    logic [SHIFT_W-1:0] shift;
    q8_t                zp;
  } cfg_t;

  localparam q8_t INT8_MIN = 8'sh80;
  localparam q8_t INT8_MAX = 8'sh7f;

  // Identity transform: M=1, S=0, zp=0 (still saturates to int8)
  localparam cfg_t CFG_IDENTITY = '{scale: 16'd1, shift: 5'd0, zp: 8'sd0};

  function automatic logic [POP_W-1:0] popcount(input logic [LANES-1:0] v);
    logic [POP_W-1:0] n;
    n = '0;
    for (int i = 0; i < LANES; i++) begin
      n = n + POP_W'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/requant_if.sv
// rtl/requant_if.sv - accumulator-in / int8-out stream handshake bundle
interface requant_if;
  import requant_pkg::*;

  logic                        in_valid;
  logic                        in_ready;
  logic [LANES-1:0][ACC_W-1:0] in_data;

  logic                        out_valid;
  logic                        out_ready;
  logic [LANES-1:0][OUT_W-1:0] out_data;
  logic [LANES-1:0]            out_sat;

  // Requantizer side
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sat
  );

  // Producer/consumer side
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sat
  );

endinterface

// File: rtl/requant_lane.sv
// rtl/requant_lane.sv - one lane: multiply, rounding shift, zero-point add and int8 clamp
module requant_lane
  import requant_pkg::*;
(
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_en,
  input  acc_t i_x,
  input  cfg_t i_cfg_s1,
  input  cfg_t i_cfg_s2,
  input  cfg_t i_cfg_s3,
  output q8_t  o_q,
  output logic o_sat
);

  prod_t r_p;
  prod_t r_q;
  q8_t   r_q8;
  logic  r_sat;

  prod_t w_p;
  prod_t w_rnd;
  prod_t w_q;
  prod_t w_v;
  q8_t   w_q8;
  logic  w_sat;

  // S1: exact signed product; the multiplier is zero-extended so it stays unsigned
  always_comb begin
    w_p = prod_t'(i_x) * prod_t'({1'b0, i_cfg_s1.scale});
  end

  // S2: add half an LSB of the result, then arithmetic shift (round half toward +inf)
  always_comb begin
    w_rnd = '0;
    if (i_cfg_s2.shift != '0) begin
      w_rnd = prod_t'(1) <<< (i_cfg_s2.shift - 5'd1);
    end
    w_q = (r_p + w_rnd) >>> i_cfg_s2.shift;
  end

  // S3: zero-point add at full width, then clamp to int8 and flag any clamping
  always_comb begin
    w_v   = r_q + prod_t'(i_cfg_s3.zp);
    w_q8  = q8_t'(w_v);
    w_sat = 1'b0;
    if (w_v > prod_t'(INT8_MAX)) begin
      w_q8  = INT8_MAX;
      w_sat = 1'b1;
    end else if (w_v < prod_t'(INT8_MIN)) begin
      w_q8  = INT8_MIN;
      w_sat = 1'b1;
    end
  end

  // Stage registers advance together on the global enable
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_p   <= '0;
      r_q   <= '0;
      r_q8  <= '0;
      r_sat <= 1'b0;
    end else if (i_en) begin
      r_p   <= w_p;
      r_q   <= w_q;
      r_q8  <= w_q8;
      r_sat <= w_sat;
    end
  end

  assign o_q   = r_q8;
  assign o_sat = r_sat;

endmodule

// File: rtl/requant_int8.sv
// rtl/requant_int8.sv - 4-lane int8 requantization stage with handshake and saturation counter
module requant_int8
  import requant_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_reset,
  requant_if.slave           bus,
  input  logic               i_cfg_we,
  input  logic [SCALE_W-1:0] i_cfg_scale,
  input  logic [SHIFT_W-1:0] i_cfg_shift,
  input  q8_t                i_cfg_zp,
  input  logic               i_sat_clr,
  output logic [CNT_W-1:0]   o_sat_count
);

  cfg_t r_shadow;
  cfg_t r_cfg_s1;
  cfg_t r_cfg_s2;
  logic r_v1;
  logic r_v2;
  logic r_v3;
  logic [CNT_W-1:0] r_sat_count;

  logic w_en;
  logic w_accept;
  logic w_xfer;
  logic [LANES-1:0][OUT_W-1:0] w_q;
  logic [LANES-1:0]            w_sat;
  logic [POP_W-1:0]            w_pop;
  logic [CNT_W:0]              w_sum;
  logic [CNT_W-1:0]            w_cnt_next;

  assign w_en          = !r_v3 || bus.out_ready;
  assign bus.in_ready  = w_en && !i_reset;
  assign w_accept      = bus.in_valid && bus.in_ready;
  assign w_xfer        = r_v3 && bus.out_ready;
  assign bus.out_valid = r_v3;
  assign bus.out_data  = w_q;
  assign bus.out_sat   = w_sat;
  assign o_sat_count   = r_sat_count;

  // Shadow config; an accepted beat samples it before this edge's update
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_shadow <= CFG_IDENTITY;
    end else if (i_cfg_we) begin
      r_shadow <= '{scale: i_cfg_scale, shift: i_cfg_shift, zp: i_cfg_zp};
    end
  end

  // Valid bits and per-stage config move in lockstep; bubbles are kept
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_v1     <= 1'b0;
      r_v2     <= 1'b0;
      r_v3     <= 1'b0;
      r_cfg_s1 <= CFG_IDENTITY;
      r_cfg_s2 <= CFG_IDENTITY;
    end else if (w_en) begin
      r_v1     <= w_accept;
      r_v2     <= r_v1;
      r_v3     <= r_v2;
      r_cfg_s1 <= r_shadow;
      r_cfg_s2 <= r_cfg_s1;
    end
  end

  // Next saturation count: clear wins over history but keeps this beat's lanes
  always_comb begin
    w_pop      = w_xfer ? popcount(w_sat) : '0;
    w_sum      = (i_sat_clr ? {(CNT_W+1){1'b0}} : {1'b0, r_sat_count}) + (CNT_W+1)'(w_pop);
    w_cnt_next = w_sum[CNT_W] ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];
  end

  // Saturating debug counter of clamped lanes
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sat_count <= '0;
    end else begin
      r_sat_count <= w_cnt_next;
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    requant_lane u_lane (
      .i_clk    (i_clk),
      .i_reset  (i_reset),
      .i_en     (w_en),
      .i_x      (acc_t'(bus.in_data[g])),
      .i_cfg_s1 (r_shadow),
      .i_cfg_s2 (r_cfg_s1),
      .i_cfg_s3 (r_cfg_s2),
      .o_q      (w_q[g]),
      .o_sat    (w_sat[g])
    );
  end

endmodule

// File: tb/tb_requant_int8.sv
// tb/tb_requant_int8.sv - self-checking bench for requant_int8
module tb_requant_int8;
  import requant_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic cfg_we;
  logic [15:0] cfg_scale;
  logic [4:0]  cfg_shift;
  logic signed [7:0] cfg_zp;
  logic sat_clr;
  logic [15:0] sat_count;

  always #5 clk = ~clk;

  requant_if bus ();

  requant_int8 dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .bus         (bus),
    .i_cfg_we    (cfg_we),
    .i_cfg_scale (cfg_scale),
    .i_cfg_shift (cfg_shift),
    .i_cfg_zp    (cfg_zp),
    .i_sat_clr   (sat_clr),
    .o_sat_count (sat_count)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { longint m; int s; longint zp; } mcfg_t;
  mcfg_t m_cfg = '{1, 0, 0};
  longint m_cnt = 0;
  logic [35:0] exp_q [$];
  int  n_xfer = 0;
  bit  saw_stall = 0;
  bit  held_v = 0;
  logic [35:0] held;

  function automatic void model_lane(input longint x, input mcfg_t c, output logic [7:0] y, output logic sat);
    longint p, r, q, v;
    p = x * c.m;
    r = p;
    if (c.s > 0) r = p + (longint'(1) << (c.s - 1));
    q = r >>> c.s;
    v = q + c.zp;
    sat = 1'b0;
    if (v > 127) begin v = 127; sat = 1'b1; end
    else if (v < -128) begin v = -128; sat = 1'b1; end
    y = v[7:0];
  endfunction

  function automatic logic [35:0] model_beat(input logic [127:0] d, input mcfg_t c);
    logic [35:0] e;
    logic [7:0] y;
    logic s;
    for (int l = 0; l < 4; l++) begin
      model_lane(longint'($signed(d[32*l +: 32])), c, y, s);
      e[8*l +: 8] = y;
      e[32+l]     = s;
    end
    return e;
  endfunction

  // Compare outputs against the model, then advance the model for the coming edge
  always @(negedge clk) begin : mon
    logic [35:0] cur;
    logic [35:0] e;
    longint pop;
    cur = {bus.out_sat, bus.out_data};
    pop = 0;
    if (!reset) begin
      check("sat_count", longint'(sat_count), m_cnt);
      check("in_ready", longint'(bus.in_ready), longint'(!bus.out_valid || bus.out_ready));
    end
    if (held_v) check("stall_hold", longint'({bus.out_valid, cur}), longint'({1'b1, held}));
    if (bus.out_valid && bus.out_ready && !reset) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("beat", longint'(cur), longint'(e));
        pop = $countones(e[35:32]);
        n_xfer++;
      end
    end
    held_v = bus.out_valid && !bus.out_ready && !reset;
    held   = cur;
    if (reset) begin
      exp_q.delete();
      m_cfg = '{1, 0, 0};
      m_cnt = 0;
    end else begin
      if (bus.in_valid && !bus.in_ready) saw_stall = 1;
      if (bus.in_valid && bus.in_ready) exp_q.push_back(model_beat(bus.in_data, m_cfg));
      if (cfg_we) m_cfg = '{longint'(cfg_scale), int'(cfg_shift), longint'(cfg_zp)};
      if (sat_clr) m_cnt = pop;
      else m_cnt = (m_cnt + pop > 65535) ? 65535 : m_cnt + pop;
    end
  end

  // ---------------- stimulus helpers (all start/end at #1 after posedge) ----------------
  task automatic set_cfg(input int m, input int s, input int zp);
    cfg_we = 1'b1; cfg_scale = 16'(m); cfg_shift = 5'(s); cfg_zp = 8'(zp);
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                      input logic [31:0] d, input bit with_cfg);
    int t;
    t = 0;
    bus.in_data  = {d, c, b, a};
    bus.in_valid = 1'b1;
    if (with_cfg) begin
      cfg_we = 1'b1; cfg_scale = 16'd2; cfg_shift = 5'd0; cfg_zp = 8'sd0;
    end
    do begin @(negedge clk); t++; end while (!bus.in_ready && t < 50);
    check("send_accept", longint'(bus.in_ready), 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    cfg_we = 1'b0;
  endtask

  task automatic expect_beat(input string name, input int e0, input int e1, input int e2,
                             input int e3, input int esat);
    int t;
    int e [4];
    e = '{e0, e1, e2, e3};
    t = 0;
    do begin @(negedge clk); t++; end while (!bus.out_valid && t < 20);
    check({name, "_latency"}, t, 3);
    for (int l = 0; l < 4; l++) check({name, "_lane"}, longint'($signed(bus.out_data[l])), e[l]);
    check({name, "_sat"}, longint'(bus.out_sat), esat);
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n0;
    reset = 1'b1; bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b1;
    cfg_we = 1'b0; cfg_scale = '0; cfg_shift = '0; cfg_zp = '0; sat_clr = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", longint'(bus.in_ready), 0);
    check("rst_out_valid", longint'(bus.out_valid), 0);
    check("rst_out_data", longint'(bus.out_data), 0);
    check("rst_out_sat", longint'(bus.out_sat), 0);
    check("rst_sat_count", longint'(sat_count), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", longint'(bus.in_ready), 1);
    @(posedge clk); #1;

    // Identity with saturation
    send(32'd5, -32'sd3, 32'd127, 32'd200, 0);
    expect_beat("identity", 5, -3, 127, 127, 4'b1000);

    // Rounding half toward +inf
    set_cfg(1, 1, 0);
    send(32'd3, -32'sd3, 32'd1, -32'sd1, 0);
    expect_beat("round", 2, -1, 1, 0, 4'b0000);

    // Zero point and negative clamp, counter and clear
    set_cfg(1, 0, -10);
    sat_clr = 1'b1; @(posedge clk); #1; sat_clr = 1'b0;
    check("clr_before_zp", longint'(sat_count), 0);
    send(-32'sd120, -32'sd200, 32'd0, 32'd137, 0);
    expect_beat("zp", -128, -128, -10, 127, 4'b0011);
    check("zp_sat_count", longint'(sat_count), 2);
    sat_clr = 1'b1; @(posedge clk); #1; sat_clr = 1'b0;
    check("zp_sat_clr", longint'(sat_count), 0);

    // Extremes: largest multiplier, largest shift
    set_cfg(16'hFFFF, 31, 0);
    send(32'h7FFFFFFF, 32'h80000000, 32'd0, 32'd1, 0);
    expect_beat("extreme", 127, -128, 0, 0, 4'b0011);

    // Backpressure with 8 back-to-back beats and a mid-stream config change
    set_cfg(1, 0, 0);
    n0 = n_xfer;
    saw_stall = 0;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          send(32'(i * 23 - 60), 32'(i * 31), 32'(-i * 17), 32'(i * 9 + 40), i == 4);
        end
      end
      begin
        for (int i = 0; i < 16; i++) begin
          bus.out_ready = !(i >= 5 && i <= 9);
          @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
      end
    join
    for (int t = 0; t < 40 && exp_q.size() != 0; t++) @(posedge clk);
    #1;
    check("bp_drained", exp_q.size(), 0);
    check("bp_beats", n_xfer - n0, 8);
    check("bp_in_ready_dropped", longint'(saw_stall), 1);

    // Reset with three beats in flight
    set_cfg(3, 0, 5);
    bus.out_ready = 1'b0;
    send(32'd10, 32'd20, 32'd30, 32'd40, 0);
    send(32'd100, 32'd200, 32'd300, 32'd400, 0);
    send(-32'sd100, -32'sd200, 32'd1, 32'd2, 0);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", longint'(bus.in_ready), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", longint'(bus.out_valid), 0);
    check("midrst_sat_count", longint'(sat_count), 0);
    check("midrst_in_ready_after", longint'(bus.in_ready), 1);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    send(32'd50, -32'sd7, 32'd300, -32'sd300, 0);
    expect_beat("after_rst", 50, -7, 127, -128, 4'b1100);

    repeat (3) @(posedge clk);
    #1;
    check("final_queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
